// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_pkg : opcode and state encodings for the sequential ALU      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package seq_alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REMU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MULT = 2'd1;
   localparam logic [1:0] ST_DIVD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_muldiv : iterative shift-add multiply / restoring divide     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module seq_alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic             rem_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_next
);

   // x: multiplicand / dividend-then-quotient, y: multiplier / divisor,
   // z: product accumulator / partial remainder.
   logic [WIDTH-1:0] r_x, r_y, r_z;
   logic [WIDTH-1:0] w_x, w_y, w_z;
   logic [WIDTH-1:0] w_x_next, w_y_next, w_z_next;
   logic [WIDTH:0]   w_shift, w_diff;
   logic             w_ge;
   logic [CNT_W-1:0] r_count;

   // The load edge already performs the first step, so a full operation
   // takes exactly WIDTH edges from acceptance.
   assign w_x = load ? a : r_x;
   assign w_y = load ? b : r_y;
   assign w_z = load ? '0 : r_z;

   assign w_shift = {w_z, w_x[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, w_y};
   assign w_ge    = ~w_diff[WIDTH];

   always_comb begin
      w_x_next = w_x;
      w_y_next = w_y;
      w_z_next = w_z;
      if (div_mode) begin
         w_x_next = {w_x[WIDTH-2:0], w_ge};
         w_z_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      end else begin
         w_x_next = {w_x[WIDTH-2:0], 1'b0};
         w_y_next = {1'b0, w_y[WIDTH-1:1]};
         w_z_next = w_y[0] ? (w_z + w_x) : w_z;
      end
   end

   assign res_next = (div_mode && !rem_sel) ? w_x_next : w_z_next;
   assign last     = (r_count == CNT_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_count <= '0;
      end else if (load) begin
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_z     <= w_z_next;
         r_count <= CNT_W'(WIDTH - 1);
      end else if (step) begin
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_z     <= w_z_next;
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu : multi-cycle ALU with valid/ready handshakes                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             busy
);

   import seq_alu_pkg::*;

   logic [1:0]       r_state, w_state_next;
   logic [3:0]       r_op, w_op_cur;
   logic [WIDTH-1:0] r_result, w_single, w_res_next;
   logic             w_accept, w_is_mul, w_is_div, w_b_zero, w_load, w_last;

   assign w_accept = (r_state == ST_IDLE) && in_valid;
   assign w_is_mul = (alu_control == OP_MUL);
   assign w_is_div = (alu_control == OP_DIVU) || (alu_control == OP_REMU);
   assign w_b_zero = (b == '0);
   assign w_load   = w_accept && (w_is_mul || (w_is_div && !w_b_zero));
   // The datapath sees the live opcode on the load edge, the latched one after.
   assign w_op_cur = (r_state == ST_IDLE) ? alu_control : r_op;

   always_comb begin
      w_single = '0;
      case (alu_control)
         OP_AND:  w_single = a & b;
         OP_OR:   w_single = a | b;
         OP_ADD:  w_single = a + b;
         OP_SUB:  w_single = a - b;
         OP_NOR:  w_single = ~(a | b);
         OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_DIVU: w_single = '1;
         OP_REMU: w_single = a;
         default: w_single = '0;
      endcase
   end

   seq_alu_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .step     (busy),
      .div_mode (w_op_cur != OP_MUL),
      .rem_sel  (w_op_cur == OP_REMU),
      .a        (a),
      .b        (b),
      .last     (w_last),
      .res_next (w_res_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               if (w_is_mul)
                  w_state_next = ST_MULT;
               else if (w_is_div && !w_b_zero)
                  w_state_next = ST_DIVD;
               else
                  w_state_next = ST_DONE;
            end
         end
         ST_MULT, ST_DIVD: begin
            if (w_last)
               w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      busy      = (r_state == ST_MULT) || (r_state == ST_DIVD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= '0;
         r_op     <= OP_AND;
      end else if (w_accept) begin
         r_op <= alu_control;
         if (!w_load)
            r_result <= w_single;
      end else if (busy && w_last) begin
         r_result <= w_res_next;
      end
   end

   assign alu_result = r_result;
   assign zero       = out_valid && (r_result == '0);

endmodule
`default_nettype wire
